// File: rtl/cnn_pkg.sv
// Shared definitions for the conv_3x3 family: kernel geometry and the
// weight scheduler state encoding.
package cnn_pkg;

    localparam int KERNEL_SIZE = 9;
    localparam int MAX_KERNELS = 512;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FILL      = 3'd1;
    localparam logic [2:0] ST_FLUSH     = 3'd2;
    localparam logic [2:0] ST_SERVE     = 3'd3;
    localparam logic [2:0] ST_WAIT_DATA = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        FILL      = ST_FILL,
        FLUSH     = ST_FLUSH,
        SERVE     = ST_SERVE,
        WAIT_DATA = ST_WAIT_DATA,
        DONE      = ST_DONE
    } sched_state_t;

endpackage

// File: rtl/conv_3x3_sched_counter.sv
// Up-counter with synchronous clear (priority over enable) and a flag
// that is high while the count equals the supplied terminal value.
module conv_3x3_sched_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             at_terminal
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/conv_3x3_weight_scheduler.sv
// Fills the 3x3 weight buffer from the upstream stream, waits for its write
// pipeline to drain, then hands out one kernel per request from the engine.
module conv_3x3_weight_scheduler #(
    parameter int DATA_WIDTH   = 32,
    parameter int KERNEL_SIZE  = cnn_pkg::KERNEL_SIZE,
    parameter int MAX_KERNELS  = cnn_pkg::MAX_KERNELS,
    parameter int KCNT_WIDTH   = 10,
    parameter int WCNT_WIDTH   = 4,
    parameter int FLUSH_CYCLES = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KCNT_WIDTH-1:0] num_kernels,
    input  logic                  w_valid,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_ready,
    output logic                  buf_valid_in,
    output logic [DATA_WIDTH-1:0] buf_in,
    output logic                  buf_load_weights,
    input  logic                  kernel_req,
    output logic                  kernel_valid,
    output logic [KCNT_WIDTH-1:0] kernels_served,
    output logic                  busy,
    output logic                  done
);

    import cnn_pkg::*;

    localparam int FCNT_WIDTH = $clog2(FLUSH_CYCLES + 1);

    sched_state_t state, state_next;

    logic [KCNT_WIDTH-1:0] nk, nk_clamped, nk_last;
    logic [WCNT_WIDTH-1:0] word_cnt;
    logic [KCNT_WIDTH-1:0] fill_kcnt;
    logic [FCNT_WIDTH-1:0] flush_cnt;
    logic word_last, fill_last, flush_last, serve_last;
    logic session_start, accept, kernel_wrap;
    logic counts_unused;

    assign session_start = (state == IDLE) && start;
    assign accept        = (state == FILL) && w_valid;
    assign kernel_wrap   = accept && word_last;
    assign nk_clamped    = (num_kernels > KCNT_WIDTH'(MAX_KERNELS)) ? KCNT_WIDTH'(MAX_KERNELS) : num_kernels;
    assign nk_last       = nk - KCNT_WIDTH'(1);
    assign busy          = (state != IDLE);
    assign counts_unused = ^{word_cnt, fill_kcnt, flush_cnt};

    // nk is only sampled from IDLE so a stray start mid-session cannot change it
    always_ff @(posedge clk) begin
        if (reset) begin
            nk <= '0;
        end else if (session_start) begin
            nk <= nk_clamped;
        end
    end

    conv_3x3_sched_counter #(.WIDTH(WCNT_WIDTH)) u_word_cnt (
        .clk(clk), .reset(reset),
        .clear(session_start || kernel_wrap), .enable(accept),
        .terminal(WCNT_WIDTH'(KERNEL_SIZE - 1)),
        .count(word_cnt), .at_terminal(word_last)
    );

    conv_3x3_sched_counter #(.WIDTH(KCNT_WIDTH)) u_fill_kcnt (
        .clk(clk), .reset(reset),
        .clear(session_start), .enable(kernel_wrap),
        .terminal(nk_last),
        .count(fill_kcnt), .at_terminal(fill_last)
    );

    conv_3x3_sched_counter #(.WIDTH(FCNT_WIDTH)) u_flush_cnt (
        .clk(clk), .reset(reset),
        .clear(session_start), .enable(state == FLUSH),
        .terminal(FCNT_WIDTH'(FLUSH_CYCLES - 1)),
        .count(flush_cnt), .at_terminal(flush_last)
    );

    conv_3x3_sched_counter #(.WIDTH(KCNT_WIDTH)) u_served_cnt (
        .clk(clk), .reset(reset),
        .clear(session_start), .enable(state == WAIT_DATA),
        .terminal(nk_last),
        .count(kernels_served), .at_terminal(serve_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fill data passes straight through so the buffer sees each word in the accept cycle
    always_comb begin
        state_next       = state;
        w_ready          = 1'b0;
        buf_valid_in     = 1'b0;
        buf_in           = '0;
        buf_load_weights = 1'b0;
        kernel_valid     = 1'b0;
        done             = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (nk_clamped == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    buf_valid_in = 1'b1;
                    buf_in       = w_data;
                    if (word_last && fill_last) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (flush_last) begin
                    state_next = SERVE;
                end
            end
            SERVE: begin
                if (kernel_req) begin
                    buf_load_weights = 1'b1;
                    state_next       = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                kernel_valid = 1'b1;
                state_next   = serve_last ? DONE : SERVE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_3x3_weight_scheduler.sv
// Scoreboard bench for the weight scheduler: fill words are queued when driven
// and popped as they appear on buf_in; session totals are checked at done.
module tb_conv_3x3_weight_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  num_kernels;
    logic        w_valid;
    logic [31:0] w_data;
    logic        w_ready;
    logic        buf_valid_in;
    logic [31:0] buf_in;
    logic        buf_load_weights;
    logic        kernel_req;
    logic        kernel_valid;
    logic [9:0]  kernels_served;
    logic        busy;
    logic        done;

    conv_3x3_weight_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .num_kernels(num_kernels),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .buf_valid_in(buf_valid_in), .buf_in(buf_in),
        .buf_load_weights(buf_load_weights), .kernel_req(kernel_req),
        .kernel_valid(kernel_valid), .kernels_served(kernels_served),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    int cyc = 0;
    int nk_exp, exp_words;
    int valid_cnt, wready_cnt, load_cnt, kv_cnt, done_cnt, served_at_done;
    int first_load, last_fill, last_load;
    bit spacing_on = 1'b0;
    bit prev_load = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Observe every cycle on the falling edge, away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (buf_valid_in === 1'b1) begin
            valid_cnt++;
            last_fill = cyc;
            if (exp_q.size() == 0) checkOutput("extra_word", 32'd1, 32'd0);
            else checkOutput("buf_in", buf_in, exp_q.pop_front());
        end
        if (w_ready === 1'b1) wready_cnt++;
        if (kernel_valid === 1'b1 || prev_load)
            checkOutput("kv_after_load", {31'd0, kernel_valid}, {31'd0, prev_load});
        if (buf_load_weights === 1'b1) begin
            if (valid_cnt < exp_words) checkOutput("load_before_fill", valid_cnt, exp_words);
            if (spacing_on && load_cnt > 0) checkOutput("load_spacing", cyc - last_load, 2);
            if (load_cnt == 0) first_load = cyc;
            last_load = cyc;
            load_cnt++;
        end
        if (kernel_valid === 1'b1) kv_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            served_at_done = kernels_served;
        end
        prev_load = (buf_load_weights === 1'b1);
    end

    task automatic startSession(input int nk_req, input bit hold_req);
        nk_exp = (nk_req > 512) ? 512 : nk_req;
        exp_words = nk_exp * 9;
        valid_cnt = 0; wready_cnt = 0; load_cnt = 0; kv_cnt = 0; done_cnt = 0;
        served_at_done = 0; first_load = 0; last_fill = 0; last_load = 0;
        exp_q.delete();
        spacing_on = hold_req;
        @(posedge clk); #1;
        start = 1'b1;
        num_kernels = nk_req[9:0];
        kernel_req = hold_req;
        @(posedge clk); #1;
        start = 1'b0;
        num_kernels = '0;
    endtask

    task automatic fillWords(input bit gaps, input bit restart_mid);
        int sent = 0;
        bit tog = 1'b1;
        while (sent < exp_words) begin
            w_valid = gaps ? tog : 1'b1;
            tog = ~tog;
            if (w_valid) begin
                w_data = sent + 1;
                exp_q.push_back(sent + 1);
                sent++;
            end else begin
                w_data = 32'hDEAD_0000 | sent;
            end
            if (restart_mid && sent == 5) begin
                start = 1'b1;
                num_kernels = 10'd5;
            end
            @(posedge clk); #1;
            start = 1'b0;
            num_kernels = '0;
        end
        repeat (2) begin
            w_valid = 1'b1;
            w_data = 32'hBAD0_0001;
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        w_data = '0;
    endtask

    task automatic serveKernels(input int pulses);
        repeat (14) @(posedge clk);
        #1;
        for (int k = 0; k < pulses; k++) begin
            kernel_req = 1'b1;
            @(posedge clk); #1;
            kernel_req = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic finishSession(input bit check_wready);
        int bound = 0;
        while (done_cnt == 0 && bound < 3000) begin
            @(negedge clk);
            bound++;
        end
        checkOutput("done_seen", {31'd0, done_cnt > 0}, 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("word_count", valid_cnt, exp_words);
        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("load_count", load_cnt, nk_exp);
        checkOutput("kv_count", kv_cnt, nk_exp);
        checkOutput("done_count", done_cnt, 1);
        checkOutput("served_at_done", served_at_done, nk_exp);
        checkOutput("served_hold", kernels_served, nk_exp);
        checkOutput("busy_idle", busy, 1'b0);
        if (check_wready) checkOutput("wready_cycles", wready_cnt, exp_words);
        if (spacing_on && nk_exp > 0) checkOutput("flush_length", first_load - last_fill, 13);
        @(posedge clk); #1;
        kernel_req = 1'b0;
    endtask

    task automatic applyStimulus(input int nk_req, input bit gaps, input bit hold_req,
                                 input bit restart_mid, input bit check_wready);
        startSession(nk_req, hold_req);
        fillWords(gaps, restart_mid);
        if (!hold_req) serveKernels(nk_exp);
        finishSession(check_wready);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_w_ready"}, w_ready, 1'b0);
        checkOutput({tag, "_buf_valid_in"}, buf_valid_in, 1'b0);
        checkOutput({tag, "_buf_in"}, buf_in, 32'd0);
        checkOutput({tag, "_load"}, buf_load_weights, 1'b0);
        checkOutput({tag, "_kernel_valid"}, kernel_valid, 1'b0);
        checkOutput({tag, "_served"}, kernels_served, 10'd0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_kernels = '0;
        w_valid = 1'b0; w_data = '0; kernel_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        applyStimulus(2, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(3, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(600, 1'b0, 1'b1, 1'b0, 1'b1);

        // Abort a 3-kernel session after the first kernel has been served
        startSession(3, 1'b0);
        fillWords(1'b0, 1'b0);
        serveKernels(1);
        checkOutput("pre_reset_kv", kv_cnt, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkAllZero("midreset");
        repeat (5) @(negedge clk);
        checkOutput("no_done_after_reset", done_cnt, 0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1);

        applyStimulus(2, 1'b0, 1'b1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
